// File: rtl/reg_access_pkg.sv
// Shared opcodes and FSM state encoding for the register-access command controller.
package reg_access_pkg;

    localparam logic [7:0] CMD_WR = 8'hAA;
    localparam logic [7:0] CMD_RD = 8'hBB;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        WR_EXEC = 3'd3,
        RD_ADDR = 3'd4,
        RD_REQ  = 3'd5,
        RD_WAIT = 3'd6,
        TX_SEND = 3'd7
    } state_e;

    // States in which the controller is waiting for the next byte of a frame.
    function automatic logic is_frame_state(state_e s);
        return (s == WR_ADDR) || (s == WR_DATA) || (s == RD_ADDR);
    endfunction

endpackage

// File: rtl/reg_access_timeout.sv
// Loadable down-counter flagging a stalled frame; only used with REG_ACCESS_CTRL_TIMEOUT_EN.
module reg_access_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic i_CLK,
    input  logic i_RST,
    input  logic load,
    input  logic enable,
    output logic expired_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge i_CLK) begin
        if (!i_RST) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(TIMEOUT_CYCLES);
        end else if (enable && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle after the last byte.
    assign expired_c = enable && !load && (count == CNT_W'(1));

endmodule

// File: rtl/reg_access_ctrl.sv
// Byte-stream command decoder driving a register file (0xAA write, 0xBB read with TX response).
// Optional inter-byte timeout is compiled in with REG_ACCESS_CTRL_TIMEOUT_EN.
module reg_access_ctrl
    import reg_access_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic [DATA_WIDTH-1:0] i_RX_Data,
    input  logic                  i_RX_Valid,
    output logic [ADDR_WIDTH-1:0] o_Address,
    output logic [DATA_WIDTH-1:0] o_WrData,
    output logic                  o_WrEn,
    output logic                  o_RdEn,
    input  logic [DATA_WIDTH-1:0] i_RdData,
    input  logic                  i_RdData_Valid,
    output logic [DATA_WIDTH-1:0] o_TX_Data,
    output logic                  o_TX_Valid,
    input  logic                  i_TX_Busy,
    output logic                  o_Busy,
    output logic                  o_Cmd_Error
);

    state_e state;
    logic   timeout_c;

`ifdef REG_ACCESS_CTRL_TIMEOUT_EN
    logic tmo_run_c;
    logic tmo_load_c;

    // Opcode byte arms the counter; each further frame byte reloads it.
    assign tmo_run_c  = is_frame_state(state);
    assign tmo_load_c = i_RX_Valid && ((state == IDLE) || tmo_run_c);

    reg_access_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_CLK     (i_CLK),
        .i_RST     (i_RST),
        .load      (tmo_load_c),
        .enable    (tmo_run_c),
        .expired_c (timeout_c)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
    assign timeout_c          = 1'b0;
`endif

    // Frame decode FSM; all outputs registered alongside the state.
    always_ff @(posedge i_CLK) begin
        if (!i_RST) begin
            state       <= IDLE;
            o_Address   <= '0;
            o_WrData    <= '0;
            o_TX_Data   <= '0;
            o_WrEn      <= 1'b0;
            o_RdEn      <= 1'b0;
            o_TX_Valid  <= 1'b0;
            o_Busy      <= 1'b0;
            o_Cmd_Error <= 1'b0;
        end else begin
            o_WrEn      <= 1'b0;
            o_RdEn      <= 1'b0;
            o_Cmd_Error <= 1'b0;

            case (state)
                IDLE: begin
                    if (i_RX_Valid) begin
                        if (i_RX_Data == DATA_WIDTH'(CMD_WR)) begin
                            state <= WR_ADDR;
                        end else if (i_RX_Data == DATA_WIDTH'(CMD_RD)) begin
                            state <= RD_ADDR;
                        end else begin
                            o_Cmd_Error <= 1'b1;
                        end
                    end
                end

                WR_ADDR: begin
                    if (i_RX_Valid) begin
                        o_Address <= i_RX_Data[ADDR_WIDTH-1:0];
                        state     <= WR_DATA;
                    end else if (timeout_c) begin
                        o_Cmd_Error <= 1'b1;
                        state       <= IDLE;
                    end
                end

                WR_DATA: begin
                    if (i_RX_Valid) begin
                        o_WrData <= i_RX_Data;
                        o_WrEn   <= 1'b1;
                        o_Busy   <= 1'b1;
                        state    <= WR_EXEC;
                    end else if (timeout_c) begin
                        o_Cmd_Error <= 1'b1;
                        state       <= IDLE;
                    end
                end

                WR_EXEC: begin
                    o_Busy <= 1'b0;
                    state  <= IDLE;
                end

                RD_ADDR: begin
                    if (i_RX_Valid) begin
                        o_Address <= i_RX_Data[ADDR_WIDTH-1:0];
                        o_RdEn    <= 1'b1;
                        o_Busy    <= 1'b1;
                        state     <= RD_REQ;
                    end else if (timeout_c) begin
                        o_Cmd_Error <= 1'b1;
                        state       <= IDLE;
                    end
                end

                RD_REQ: begin
                    state <= RD_WAIT;
                end

                RD_WAIT: begin
                    if (i_RdData_Valid) begin
                        o_TX_Data  <= i_RdData;
                        o_TX_Valid <= 1'b1;
                        state      <= TX_SEND;
                    end
                end

                // Byte is held until the transmitter reports a non-busy cycle.
                TX_SEND: begin
                    if (!i_TX_Busy) begin
                        o_TX_Valid <= 1'b0;
                        o_Busy     <= 1'b0;
                        state      <= IDLE;
                    end
                end

                default: begin
                    o_TX_Valid <= 1'b0;
                    o_Busy     <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Directed bench for reg_access_ctrl: frame-level reference model, per-cycle compare and literal spot checks.
module tb_reg_access_ctrl;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic [7:0] rx_data  = 8'h00;
    logic       rx_valid = 1'b0;
    logic       tx_busy  = 1'b0;
    logic [3:0] addr;
    logic [7:0] wrdata;
    logic       wren;
    logic       rden;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       busy;
    logic       cmd_err;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    reg_access_ctrl #(
        .DATA_WIDTH     (8),
        .ADDR_WIDTH     (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .i_CLK          (clk),
        .i_RST          (rst_n),
        .i_RX_Data      (rx_data),
        .i_RX_Valid     (rx_valid),
        .o_Address      (addr),
        .o_WrData       (wrdata),
        .o_WrEn         (wren),
        .o_RdEn         (rden),
        .i_RdData       (rd_data),
        .i_RdData_Valid (rd_valid),
        .o_TX_Data      (tx_data),
        .o_TX_Valid     (tx_valid),
        .i_TX_Busy      (tx_busy),
        .o_Busy         (busy),
        .o_Cmd_Error    (cmd_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Register-file stand-in: registered read, one cycle after o_RdEn.
    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= 8'h00;
            for (int i = 0; i < 16; i++) mem[i] <= 8'(8'h10 + i);
        end else begin
            rd_valid <= rden;
            rd_data  <= mem[addr];
            if (wren) mem[addr] <= wrdata;
        end
    end

    // Reference model: collects accepted frame bytes, predicts outputs for the cycle after each edge.
    logic [7:0] frame [$];
    bit         m_wr, m_rd, m_wait, m_tx, m_err;
    logic [3:0] m_addr  = 4'h0;
    logic [7:0] m_wdata = 8'h00;
    logic [7:0] m_txd   = 8'h00;
`ifdef REG_ACCESS_CTRL_TIMEOUT_EN
    localparam int TMO = 16;
    int m_silent = 0;
`endif

    always @(posedge clk) begin : model
        bit was_busy;
        if (!rst_n) begin
            frame.delete();
            m_wr = 0; m_rd = 0; m_wait = 0; m_tx = 0; m_err = 0;
            m_addr = 4'h0; m_wdata = 8'h00; m_txd = 8'h00;
`ifdef REG_ACCESS_CTRL_TIMEOUT_EN
            m_silent = 0;
`endif
        end else begin
            was_busy = m_wr || m_rd || m_wait || m_tx;
            m_err = 0;
            if (m_tx && !tx_busy) m_tx = 0;
            if (m_wait && rd_valid) begin
                m_wait = 0;
                m_tx   = 1;
                m_txd  = rd_data;
            end
            if (m_rd) m_wait = 1;
            m_wr = 0;
            m_rd = 0;
            if (rx_valid && !was_busy) begin
`ifdef REG_ACCESS_CTRL_TIMEOUT_EN
                m_silent = 0;
`endif
                if (frame.size() == 0 && rx_data != 8'hAA && rx_data != 8'hBB) m_err = 1;
                else frame.push_back(rx_data);
                if (frame.size() == 2) m_addr = frame[1][3:0];
                if (frame.size() == 2 && frame[0] == 8'hBB) begin
                    m_rd = 1;
                    frame.delete();
                end else if (frame.size() == 3) begin
                    m_wdata = frame[2];
                    m_wr    = 1;
                    frame.delete();
                end
            end
`ifdef REG_ACCESS_CTRL_TIMEOUT_EN
            else if (frame.size() != 0) begin
                m_silent++;
                if (m_silent == TMO) begin
                    m_err = 1;
                    m_silent = 0;
                    frame.delete();
                end
            end
`endif
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("wr_en",    32'(wren),     32'(m_wr));
            check("rd_en",    32'(rden),     32'(m_rd));
            check("busy",     32'(busy),     32'(m_wr | m_rd | m_wait | m_tx));
            check("tx_valid", 32'(tx_valid), 32'(m_tx));
            check("cmd_err",  32'(cmd_err),  32'(m_err));
            check("address",  32'(addr),     32'(m_addr));
            check("wr_data",  32'(wrdata),   32'(m_wdata));
            check("tx_data",  32'(tx_data),  32'(m_txd));
        end
    end

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_tx(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (tx_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        bit ok;
        int k;

        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_wren",  32'(wren),     32'd0);
        check("rst_busy",  32'(busy),     32'd0);
        check("rst_txv",   32'(tx_valid), 32'd0);
        check("rst_addr",  32'(addr),     32'd0);
        check("rst_txd",   32'(tx_data),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write AA,05,3C
        send(8'hAA); send(8'h05); send(8'h3C);
        check("wr_pulse", 32'(wren),   32'd1);
        check("wr_addr",  32'(addr),   32'h5);
        check("wr_val",   32'(wrdata), 32'h3C);
        @(negedge clk);
        check("wr_single", 32'(wren), 32'd0);

        // Read BB,05 back-to-back, transmitter free
        send(8'hBB); send(8'h05);
        check("rd_pulse", 32'(rden), 32'd1);
        check("rd_addr",  32'(addr), 32'h5);
        wait_tx(ok);
        check("rd_tx_seen", 32'(ok),      32'd1);
        check("rd_tx_data", 32'(tx_data), 32'h3C);
        @(negedge clk);
        check("rd_tx_drop", 32'(tx_valid), 32'd0);

        // Write with upper address bits set, then read while TX busy for 10 cycles
        send(8'hAA); send(8'h1C); send(8'hA5);
        check("wr_addr_trunc", 32'(addr), 32'hC);
        @(negedge clk);
        tx_busy = 1'b1;
        send(8'hBB); send(8'h0C);
        wait_tx(ok);
        check("hold_seen", 32'(ok), 32'd1);
        for (int i = 0; i < 10; i++) begin
            check("hold_valid", 32'(tx_valid), 32'd1);
            check("hold_data",  32'(tx_data),  32'hA5);
            rx_data  = 8'h55;
            rx_valid = (i == 3);
            @(negedge clk);
        end
        rx_valid = 1'b0;
        check("hold_last", 32'(tx_valid), 32'd1);
        tx_busy = 1'b0;
        @(negedge clk);
        check("hold_drop", 32'(tx_valid), 32'd0);

        // Bad opcode then a clean write
        send(8'h55);
        check("err_pulse", 32'(cmd_err), 32'd1);
        check("err_nowr",  32'(wren),    32'd0);
        @(negedge clk);
        check("err_single", 32'(cmd_err), 32'd0);
        send(8'hAA); send(8'h02); send(8'hFF);
        check("wr2_pulse", 32'(wren),   32'd1);
        check("wr2_addr",  32'(addr),   32'h2);
        check("wr2_data",  32'(wrdata), 32'hFF);
        @(negedge clk);

        // Reset mid-frame abandons the write
        send(8'hAA); send(8'h07);
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("rst_mid_nowr", 32'(wren), 32'd0);
        end
        rst_n = 1'b1;
        send(8'hBB); send(8'h07);
        wait_tx(ok);
        check("post_rst_seen", 32'(ok),      32'd1);
        check("post_rst_data", 32'(tx_data), 32'h17);
        @(negedge clk);

`ifdef REG_ACCESS_CTRL_TIMEOUT_EN
        send(8'hAA);
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (cmd_err === 1'b1) begin
                k = i;
                break;
            end
        end
        check("tmo_cycle", 32'(k),    32'd16);
        check("tmo_busy",  32'(busy), 32'd0);
        @(negedge clk);
        send(8'hAA); send(8'h03); send(8'h44);
        check("tmo_recover", 32'(wren), 32'd1);
`else
        k = 0;
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
